// File: rtl/demorgan_pkg.sv
// Shared types and constants for the De Morgan second-law demonstration block.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package demorgan_pkg;

  // Index of an input combination, formed as {a,b}.
  typedef logic [1:0] combo_t;

  localparam combo_t COMBO_00 = 2'd0;
  localparam combo_t COMBO_01 = 2'd1;
  localparam combo_t COMBO_10 = 2'd2;
  localparam combo_t COMBO_11 = 2'd3;

  localparam int unsigned NUM_COMBOS = 4;

  // Packs the two operands into a combination index.
  function automatic combo_t combo_of(input logic a, input logic b);
    return {a, b};
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with enable; holds at all-ones instead of wrapping.
// Latency: count updates on the rising clk edge after en is sampled high.
// Backpressure: none; en is a plain strobe.
//
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset, clears cnt
//   en     increment request for this edge
//   cnt    current count, W bits
module sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en,
  output logic [W-1:0] cnt
);

  logic at_max;

  assign at_max = &cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (en && !at_max) begin
      cnt <= cnt + W'(1);
    end
  end

endmodule

// File: rtl/demorgan_2nd_b.sv
// De Morgan second law, right-hand form: e = ~a | ~b (NAND), plus a clocked monitor.
// Latency: e is combinational (0 cycles); e_q, mismatch, hit_vec and counters update 1 clk edge later.
// Backpressure: none; inputs are sampled every rising edge.
//
// Ports:
//   clk, rst_n   monitor clock and async active-low reset (e does not depend on them)
//   a, b         operands
//   e            combinational ~a | ~b
//   e_q          e registered on clk
//   mismatch     sticky: left form ~(a&b) disagreed with right form on a sampled edge
//   hit_vec      sticky per-combination seen flags, bit index = {a,b}
//   cov_done     all four combinations seen
//   cnt_sel      selects which combination counter appears on cnt_out
//   cnt_out      saturating hit count of the selected combination
module demorgan_2nd_b
  import demorgan_pkg::*;
#(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             a,
  input  logic             b,
  output logic             e,
  output logic             e_q,
  output logic             mismatch,
  output logic [3:0]       hit_vec,
  output logic             cov_done,
  input  logic [1:0]       cnt_sel,
  output logic [CNT_W-1:0] cnt_out
);

  // Right-hand form built literally: two inverters feeding an OR.
  logic a_inv;
  logic b_inv;

  assign a_inv = ~a;
  assign b_inv = ~b;
  assign e     = a_inv | b_inv;

  // Left-hand form exists only so the monitor can compare the two.
  logic e_left;

  assign e_left = ~(a & b);

  combo_t combo;

  assign combo = combo_of(a, b);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      e_q      <= 1'b0;
      mismatch <= 1'b0;
      hit_vec  <= 4'b0000;
    end else begin
      e_q           <= e;
      mismatch      <= mismatch | (e_left ^ e);
      hit_vec[combo] <= 1'b1;
    end
  end

  assign cov_done = &hit_vec;

  logic [CNT_W-1:0] cnt_arr [NUM_COMBOS];

  for (genvar i = 0; i < NUM_COMBOS; i++) begin : g_cnt
    sat_counter #(
      .W (CNT_W)
    ) u_cnt (
      .clk   (clk),
      .rst_n (rst_n),
      .en    (combo == combo_t'(i)),
      .cnt   (cnt_arr[i])
    );
  end

  assign cnt_out = cnt_arr[cnt_sel];

endmodule

// File: tb/tb_demorgan_2nd_b.sv
module tb_demorgan_2nd_b;

  logic       clk = 1'b0;
  logic       clk_en = 1'b0;
  logic       rst_n;
  logic       a, b;
  logic [1:0] cnt_sel;
  logic       e, e_q, mismatch, cov_done;
  logic [3:0] hit_vec;
  logic [7:0] cnt_out;

  // Narrow-counter instance for saturation checks, with its own reset and inputs.
  logic       rst2_n;
  logic       a2, b2;
  logic [1:0] cnt_sel2;
  logic       e2, e_q2, mismatch2, cov_done2;
  logic [3:0] hit_vec2;
  logic [1:0] cnt_out2;

  int checks = 0;
  int errors = 0;

  demorgan_2nd_b #(.CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .a(a), .b(b), .e(e), .e_q(e_q),
    .mismatch(mismatch), .hit_vec(hit_vec), .cov_done(cov_done),
    .cnt_sel(cnt_sel), .cnt_out(cnt_out)
  );

  demorgan_2nd_b #(.CNT_W(2)) dut2 (
    .clk(clk), .rst_n(rst2_n), .a(a2), .b(b2), .e(e2), .e_q(e_q2),
    .mismatch(mismatch2), .hit_vec(hit_vec2), .cov_done(cov_done2),
    .cnt_sel(cnt_sel2), .cnt_out(cnt_out2)
  );

  initial forever #5 clk = clk_en ? ~clk : 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // Reference model: what has been seen, how often, and the NAND of the last sample.
  logic [3:0] m_hit = 4'b0;
  int         m_cnt [4] = '{0, 0, 0, 0};
  logic       m_eq = 1'b0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_hit = 4'b0;
      for (int i = 0; i < 4; i++) m_cnt[i] = 0;
      m_eq = 1'b0;
    end else begin
      int idx;
      idx = a * 2 + b;
      m_hit[idx] = 1'b1;
      if (m_cnt[idx] < 255) m_cnt[idx] = m_cnt[idx] + 1;
      m_eq = !(a && b);
    end
  end

  // Cycle-by-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    chk("e_comb",   {31'b0, e},        {31'b0, !(a && b)});
    chk("e_q",      {31'b0, e_q},      {31'b0, m_eq});
    chk("mismatch", {31'b0, mismatch}, 32'd0);
    chk("hit_vec",  {28'b0, hit_vec},  {28'b0, m_hit});
    chk("cov_done", {31'b0, cov_done}, {31'b0, (m_hit == 4'hF)});
    chk("cnt_out",  {24'b0, cnt_out},  m_cnt[cnt_sel]);
  end

  // Apply a combination, then step to just after the edge that samples it.
  task automatic drive(input logic av, input logic bv);
    a = av;
    b = bv;
    @(posedge clk);
    #2;
  endtask

  task automatic chk_all_cnt(input string name, input logic [7:0] exp0, input logic [7:0] exp1,
                             input logic [7:0] exp2, input logic [7:0] exp3);
    logic [7:0] exp_arr [4];
    exp_arr = '{exp0, exp1, exp2, exp3};
    for (int i = 0; i < 4; i++) begin
      cnt_sel = 2'(i);
      #1;
      chk(name, {24'b0, cnt_out}, {24'b0, exp_arr[i]});
    end
  endtask

  initial begin
    a = 0; b = 0; rst_n = 0; rst2_n = 0; a2 = 0; b2 = 1; cnt_sel = 0; cnt_sel2 = 0;

    // Combinational path with no clock running.
    #1;   chk("e_00", {31'b0, e}, 32'd1);
    #49 a = 1;
    #1;   chk("e_10", {31'b0, e}, 32'd1);
    #49 a = 0; b = 1;
    #1;   chk("e_01", {31'b0, e}, 32'd1);
    #49 a = 1;
    #1;   chk("e_11", {31'b0, e}, 32'd0);
    #49;

    // Reset with clock running.
    a = 0; b = 0;
    clk_en = 1;
    repeat (2) @(posedge clk);
    #2;
    chk("rst_e_q", {31'b0, e_q}, 32'd0);
    chk("rst_hit", {28'b0, hit_vec}, 32'd0);
    chk("rst_cov", {31'b0, cov_done}, 32'd0);
    chk_all_cnt("rst_cnt", 8'd0, 8'd0, 8'd0, 8'd0);
    rst_n = 1;
    drive(1, 1);
    chk("first_e_q", {31'b0, e_q}, 32'd0);
    chk("first_hit", {28'b0, hit_vec}, 32'h8);

    // Full sweep from a clean reset.
    rst_n = 0; #1; rst_n = 1;
    drive(0, 0); drive(0, 1); drive(1, 0); drive(1, 1);
    chk("sweep_hit", {28'b0, hit_vec}, 32'hF);
    chk("sweep_cov", {31'b0, cov_done}, 32'd1);
    chk("sweep_mis", {31'b0, mismatch}, 32'd0);
    chk_all_cnt("sweep_cnt", 8'd1, 8'd1, 8'd1, 8'd1);

    // Reset in the middle of a sweep clears before the next edge.
    rst_n = 0; #1; rst_n = 1;
    drive(0, 0); drive(0, 1);
    chk("mid_hit_pre", {28'b0, hit_vec}, 32'h3);
    rst_n = 0;
    #1;
    chk("mid_hit_clr", {28'b0, hit_vec}, 32'd0);
    chk_all_cnt("mid_cnt_clr", 8'd0, 8'd0, 8'd0, 8'd0);
    rst_n = 1;
    drive(1, 0); drive(1, 1); drive(0, 0);
    chk("mid_cov_3", {31'b0, cov_done}, 32'd0);
    drive(0, 1);
    chk("mid_cov_4", {31'b0, cov_done}, 32'd1);

    // Saturation on the 2-bit instance: six hits of 01 clamp at 3.
    rst2_n = 1;
    repeat (6) @(posedge clk);
    #2;
    for (int i = 0; i < 4; i++) begin
      cnt_sel2 = 2'(i);
      #1;
      chk("sat_cnt", {30'b0, cnt_out2}, (i == 1) ? 32'd3 : 32'd0);
    end
    chk("sat_hit", {28'b0, hit_vec2}, 32'h2);

    // Random operands and counter selection.
    repeat (100) begin
      a = 1'($urandom);
      b = 1'($urandom);
      cnt_sel = 2'($urandom_range(0, 3));
      @(posedge clk);
      #2;
    end
    chk("rand_mis", {31'b0, mismatch}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
